// File: rtl/instruction_fetch.sv
// instruction_fetch: RISC-V fetch stage (PC, one outstanding imem read, valid/ready to decode, redirects); define FETCH_MISALIGN_TRAP_EN to fault on misaligned redirect targets
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        fetch_fault_o
);
  localparam logic [2:0] S_RESET = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_VALID = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;
  logic [2:0] state, nxt, go;
  logic [31:0] pc, drain_addr, rpc, tgt;
  logic mis;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign rpc = redirect_pc_i;
  assign mis = |tgt[1:0];
  assign fetch_fault_o = state == S_FAULT;
`else
  logic unused_low;
  assign unused_low = ^redirect_pc_i[1:0];
  assign rpc = {redirect_pc_i[31:2], 2'b00};
  assign mis = 1'b0;
  assign fetch_fault_o = 1'b0;
`endif
  assign tgt = redirect_i ? rpc : pc;
  assign go = mis ? S_FAULT : S_FETCH;
  assign imem_req_o = state == S_FETCH || state == S_DRAIN;
  assign imem_addr_o = state == S_DRAIN ? drain_addr : pc;
  assign instr_valid_o = state == S_VALID;
  always_comb begin
    nxt = state == S_RESET ? (redirect_i ? go : S_FETCH)
        : state == S_FETCH ? (redirect_i ? (imem_ack_i ? go : S_DRAIN) : imem_ack_i ? S_VALID : S_FETCH)
        : state == S_VALID ? (redirect_i ? go : instr_ready_i ? S_FETCH : S_VALID)
        : state == S_DRAIN ? (imem_ack_i ? go : S_DRAIN)
        : state == S_FAULT ? (redirect_i && !mis ? S_FETCH : S_FAULT)
        : S_RESET;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_RESET;
      pc <= RESET_PC;
      drain_addr <= RESET_PC;
      instruction_o <= 32'h0000_0013;
      pc_o <= '0;
    end else begin
      state <= nxt;
      pc <= redirect_i ? rpc : (state == S_FETCH && imem_ack_i) ? pc + 32'd4 : pc;
      if (state == S_FETCH) drain_addr <= pc;
      if (state == S_FETCH && nxt == S_VALID) begin
        instruction_o <= imem_rdata_i;
        pc_o <= pc;
      end
      if (nxt == S_FAULT) pc_o <= tgt;
    end
  end
endmodule
